// File: rtl/uart_pkg.sv
// uart_pkg: shared UART state type and width helpers for transmitter and receiver
package uart_pkg;
  typedef enum logic {IDLE, SEND} state_t;
  function automatic int w_baud(input int cpp);
    return cpp > 1 ? $clog2(cpp) : 1;
  endfunction
  function automatic int w_bit(input int p);
    return p > 1 ? $clog2(p) : 1;
  endfunction
  localparam int DEF_CLOCKS_PER_PULSE = 4;
  localparam int DEF_BITS_PER_WORD = 8;
  localparam int DEF_PACKET_SIZE_TX = DEF_BITS_PER_WORD + 5;
  localparam int N_STOP = DEF_PACKET_SIZE_TX - DEF_BITS_PER_WORD - 1;
  localparam int W_BAUD = w_baud(DEF_CLOCKS_PER_PULSE);
  localparam int W_BIT = w_bit(DEF_PACKET_SIZE_TX);
endpackage

// File: rtl/uart_tx_framer_if.sv
// uart_tx_framer_if: valid/ready word stream feeding the UART transmitter
interface uart_tx_framer_if #(parameter int BITS_PER_WORD = 8);
  logic s_valid;
  logic [BITS_PER_WORD-1:0] s_data;
  logic s_ready;
  modport master (output s_valid, s_data, input s_ready);
  modport slave (input s_valid, s_data, output s_ready);
endinterface

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: clearable bit-period counter with a one-cycle tick at terminal count
module uart_baud_tick #(
  parameter int CLOCKS_PER_PULSE = 4,
  parameter int W = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);
  logic [W-1:0] cnt;
  assign tick = en && cnt == W'(CLOCKS_PER_PULSE - 1);
  // wrap to zero on terminal count so the next bit period starts aligned
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else if (clr || tick) cnt <= '0;
    else if (en) cnt <= cnt + 1'b1;
endmodule

// File: rtl/uart_tx_framer.sv
// uart_tx_framer: serialises held words into start/data/stop frames on tx
module uart_tx_framer
  import uart_pkg::*;
#(
  parameter int CLOCKS_PER_PULSE = 4,
  parameter int BITS_PER_WORD = 8,
  parameter int PACKET_SIZE_TX = BITS_PER_WORD + 5
) (
  input  logic clk,
  input  logic rst,
  uart_tx_framer_if.slave s,
  output logic tx,
  output logic busy
);
  localparam int WB = w_baud(CLOCKS_PER_PULSE);
  localparam int WT = w_bit(PACKET_SIZE_TX);
  localparam int NS = PACKET_SIZE_TX - BITS_PER_WORD - 1;
  state_t state;
  logic [PACKET_SIZE_TX-1:0] shifter, frame;
  logic [WT-1:0] bit_cnt;
  logic [BITS_PER_WORD-1:0] hold;
  logic hold_full, tick, last, load;
  assign frame = {{NS{1'b1}}, hold, 1'b0};
  assign last = tick && bit_cnt == WT'(PACKET_SIZE_TX - 1);
  assign load = hold_full && (state == IDLE || last);
  assign s.s_ready = !hold_full;
  assign busy = state == SEND || hold_full;
  uart_baud_tick #(.CLOCKS_PER_PULSE(CLOCKS_PER_PULSE), .W(WB)) u_baud (
    .clk(clk),
    .rst(rst),
    .clr(load),
    .en(state == SEND),
    .tick(tick)
  );
  // holding register plus frame FSM; a pending word reloads on the last stop-bit edge so frames abut
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      shifter <= '1;
      bit_cnt <= '0;
      hold <= '0;
      hold_full <= 1'b0;
      tx <= 1'b1;
    end else begin
      if (load) hold_full <= 1'b0;
      else if (s.s_valid && !hold_full) begin
        hold <= s.s_data;
        hold_full <= 1'b1;
      end
      if (load) begin
        shifter <= frame;
        bit_cnt <= '0;
        state <= SEND;
        tx <= 1'b0;
      end else if (last) begin
        state <= IDLE;
        tx <= 1'b1;
      end else if (tick) begin
        shifter <= {1'b1, shifter[PACKET_SIZE_TX-1:1]};
        bit_cnt <= bit_cnt + 1'b1;
        tx <= shifter[1];
      end
    end
endmodule
